// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a word-addressed SRAM with byte strobes.
// One outstanding transaction, fixed latency, optional LFSR accept throttle.
package dbus_sram_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | ready to accept; addr_ok follows valid unless throttled
// WAIT  | transaction latched, latency counter running
// RESP  | data_ok cycle; old word returned, strobed lanes written at edge
module dbus_sram_responder
   import dbus_sram_pkg::*;
#(
   parameter int          MEM_WORDS = 1024,
   parameter int          LATENCY   = 2,
   parameter bit          STALL_EN  = 1'b0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp
);
   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt;
   logic [3:0]     cnt_dec;
   logic [AW-1:0]  idx;
   logic [3:0]     strb;
   logic [31:0]    wdata;
   logic [31:0]    data_q;
   logic [31:0]    mem [MEM_WORDS];
   logic           throttle;
   logic           accept;
   logic           unused;

   assign unused  = ^{dreq.size, dreq.addr[31:AW+2], dreq.addr[1:0]};
   assign accept  = dresp.addr_ok;
   assign cnt_dec = cnt - 4'd1;

   generate
      if (STALL_EN) begin : g_lfsr
         logic [15:0] lfsr;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               lfsr <= LFSR_SEED;
            else if (state == IDLE)
               lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         end
         assign throttle = lfsr[0];
      end else begin : g_no_lfsr
         logic [15:0] unused_seed;
         assign unused_seed = LFSR_SEED;
         assign throttle    = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         data_q <= 32'h0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= 4'(LATENCY);
         else if (state == WAIT)
            cnt <= cnt_dec;
         if (state == RESP)
            data_q <= mem[idx];
      end
   end

   // Request fields carry no reset; they are only consumed after an accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx   <= dreq.addr[AW+1:2];
         strb  <= dreq.strobe;
         wdata <= dreq.data;
      end
   end

   always_ff @(posedge clk) begin
      if (state == RESP) begin
         for (int i = 0; i < 4; i++)
            if (strb[i])
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   always_comb begin
      state_nxt = state;
      dresp     = '0;
      dresp.addr_ok = (state == IDLE) && dreq.valid && !throttle;
      dresp.data_ok = (state == RESP);
      dresp.data    = (state == RESP) ? mem[idx] : data_q;
      case (state)
         IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt_dec == 4'd1) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Initiator must hold the request while it waits for addr_ok.
   assert property (@(posedge clk) disable iff (reset)
      (dreq.valid && !dresp.addr_ok) |=> (!dreq.valid || $stable(dreq)));

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed checks of dbus_sram_responder plus a throttled random run
// against a scoreboard.
module tb_dbus_sram_responder;
   import dbus_sram_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   dbus_req_t  req0, req1;
   dbus_resp_t resp0, resp1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] lfsr_m;
   int          cnt_m;
   bit          stall_on = 1'b0;
   logic [31:0] sb    [16];
   bit          known [16];

   always #5 clk = ~clk;

   dbus_sram_responder u0 (
      .clk(clk), .reset(reset), .dreq(req0), .dresp(resp0));

   dbus_sram_responder #(.STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) u1 (
      .clk(clk), .reset(reset), .dreq(req1), .dresp(resp1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Independent model of the throttled responder's idle/busy timing and LFSR.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_m <= 16'hACE1;
         cnt_m  <= 0;
      end else if (cnt_m == 0) begin
         if (req1.valid && !lfsr_m[0])
            cnt_m <= 2;
         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      end else begin
         cnt_m <= cnt_m - 1;
      end
   end

   always @(negedge clk) begin
      if (stall_on) begin
         chk("stall_addr_ok", resp1.addr_ok, (cnt_m == 0) && req1.valid && !lfsr_m[0]);
         chk("throttle_block", resp1.addr_ok & lfsr_m[0], 1'b0);
         chk("stall_data_ok", resp1.data_ok, cnt_m == 1);
      end
   end

   // Called just after a rising edge; returns on the edge after data_ok.
   task automatic txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output int wait_n, output int lat);
      req0 = '{valid: 1'b1, addr: a, size: 2'd2, strobe: s, data: d};
      wait_n = 0;
      @(negedge clk);
      while (!resp0.addr_ok && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      @(posedge clk); #1;
      req0.valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp0.data_ok && lat < 40);
      rd = resp0.data;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      int          wn, lat, dcnt, k;
      logic [9:0]  ao, dk;
      logic [31:0] got [3];
      dbus_req_t   b2b [3];

      reset = 1'b1;
      req0  = '0;
      req1  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_addr_ok", resp0.addr_ok, 1'b0);
      chk("reset_data_ok", resp0.data_ok, 1'b0);
      chk("reset_data", resp0.data, 32'h0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      txn(32'h20, 4'hF, 32'h0, rd, wn, lat);
      txn(32'h10, 4'hF, 32'hDEADBEEF, rd, wn, lat);
      chk("wr_accept_cycle", wn, 0);
      chk("wr_latency", lat, 2);
      txn(32'h10, 4'h0, 32'h0, rd, wn, lat);
      chk("rd_latency", lat, 2);
      chk("rd_data", rd, 32'hDEADBEEF);
      txn(32'h10, 4'b0101, 32'h11223344, rd, wn, lat);
      chk("merge_old_data", rd, 32'hDEADBEEF);
      txn(32'h10, 4'h0, 32'h0, rd, wn, lat);
      chk("merge_result", rd, 32'hDE22BE44);

      txn(32'h0000_1004, 4'hF, 32'hCAFEF00D, rd, wn, lat);
      txn(32'h0000_0004, 4'h0, 32'h0, rd, wn, lat);
      chk("wrap_low", rd, 32'hCAFEF00D);
      txn(32'hFFFF_F004, 4'h0, 32'h0, rd, wn, lat);
      chk("wrap_high", rd, 32'hCAFEF00D);
      @(negedge clk);
      chk("hold_data", resp0.data, 32'hCAFEF00D);
      chk("hold_data_ok", resp0.data_ok, 1'b0);
      @(posedge clk); #1;

      b2b[0] = '{valid: 1'b1, addr: 32'h10, size: 2'd2, strobe: 4'h0, data: 32'h0};
      b2b[1] = '{valid: 1'b1, addr: 32'h04, size: 2'd2, strobe: 4'h0, data: 32'h0};
      b2b[2] = '{valid: 1'b1, addr: 32'h20, size: 2'd2, strobe: 4'h0, data: 32'h0};
      req0 = b2b[0];
      k = 0; dcnt = 0; ao = '0; dk = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         ao[c] = resp0.addr_ok;
         dk[c] = resp0.data_ok;
         if (resp0.data_ok && dcnt < 3) begin
            got[dcnt] = resp0.data;
            dcnt++;
         end
         @(posedge clk); #1;
         if (ao[c]) begin
            k++;
            if (k < 3) req0 = b2b[k];
            else req0.valid = 1'b0;
         end
      end
      chk("b2b_addr_ok", 32'(ao), 32'b0001001001);
      chk("b2b_data_ok", 32'(dk), 32'b0100100100);
      chk("b2b_data0", got[0], 32'hDE22BE44);
      chk("b2b_data1", got[1], 32'hCAFEF00D);
      chk("b2b_data2", got[2], 32'h0);

      req0 = '{valid: 1'b1, addr: 32'h20, size: 2'd2, strobe: 4'hF, data: 32'h12345678};
      @(negedge clk);
      chk("rst_op_accept", resp0.addr_ok, 1'b1);
      @(posedge clk); #1;
      req0.valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_op_addr_ok", resp0.addr_ok, 1'b0);
      chk("rst_op_data_ok", resp0.data_ok, 1'b0);
      chk("rst_op_data", resp0.data, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (resp0.data_ok) dcnt++;
      end
      chk("rst_op_no_data_ok", dcnt, 0);
      @(posedge clk); #1;
      txn(32'h20, 4'h0, 32'h0, rd, wn, lat);
      chk("rst_op_sram_kept", rd, 32'h0);

      stall_on = 1'b1;
      for (int i = 0; i < 200; i++) begin
         int          idx, n, gap;
         logic [31:0] a, d;
         logic [3:0]  s;
         idx = $urandom_range(0, 15);
         s   = 4'($urandom_range(0, 15));
         if (i < 16) begin
            idx = i;
            s   = 4'hF;
         end
         d = $urandom();
         a = ($urandom() & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
         req1 = '{valid: 1'b1, addr: a, size: 2'($urandom_range(0, 2)), strobe: s, data: d};
         n = 0;
         @(negedge clk);
         while (!resp1.addr_ok && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("stall_accepted", resp1.addr_ok, 1'b1);
         @(posedge clk); #1;
         req1.valid = 1'b0;
         n = 0;
         @(negedge clk);
         while (!resp1.data_ok && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("stall_resp", resp1.data_ok, 1'b1);
         if (known[idx]) chk("stall_data", resp1.data, sb[idx]);
         for (int l = 0; l < 4; l++)
            if (s[l]) sb[idx][8*l +: 8] = d[8*l +: 8];
         known[idx] = 1'b1;
         @(posedge clk); #1;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
      end
      stall_on = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
